// File: rtl/rf_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package rf_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  // Address of the hardwired-zero register.
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: x0 forcing, write-first bypass, and a busy
// flag that drops in the same cycle the pending value is written back.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [NREGS*XLEN-1:0] rf_i,
  input  logic [NREGS-1:0]      busy_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [XLEN-1:0]       wr_data_i,
  input  logic [AW-1:0]         rs_addr_i,
  output logic [XLEN-1:0]       rs_data_o,
  output logic                  rs_busy_o
);

  logic is_zero;
  logic byp;

  assign is_zero = (rs_addr_i == AW'(REG_ZERO));
  assign byp     = wr_en_i && (wr_addr_i == rs_addr_i);

  // Resolve data: x0 first, then the in-flight writeback, then storage.
  always_comb begin
    rs_data_o = rf_i[int'(rs_addr_i)*XLEN +: XLEN];
    if (byp) begin
      rs_data_o = wr_data_i;
    end
    if (is_zero) begin
      rs_data_o = '0;
    end
  end

  // A register being written this cycle is already available via the bypass.
  always_comb begin
    rs_busy_o = busy_i[rs_addr_i] & ~byp & ~is_zero;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with NRD bypassed read ports, one write port and a
// per-register busy scoreboard that raises a decode stall.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEF,
  parameter int  NREGS = NREGS_DEF,
  parameter int  NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rs_addr,
  input  logic [NRD-1:0]      rs_used,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  output logic                stall,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush
);

  // x0 has no storage: arrays start at index 1.
  logic [XLEN-1:0]       rf_q [1:NREGS-1];
  logic [XLEN-1:0]       rf_d [1:NREGS-1];
  logic [NREGS-1:1]      busy_q;
  logic [NREGS-1:1]      busy_d;
  logic [NREGS*XLEN-1:0] rf_flat;
  logic [NREGS-1:0]      busy_vec;
  logic                  wr_ok;
  logic                  iss_ok;
  logic                  byp_en;

  assign wr_ok  = wr_en  && (wr_addr != AW'(REG_ZERO));
  assign iss_ok = iss_en && (iss_rd  != AW'(REG_ZERO));
  // Bypass is suppressed while in reset so reads stay zero.
  assign byp_en = wr_en & rst_n;

  // Next-state storage: only the addressed non-zero register takes wr_data.
  always_comb begin
    for (int r = 1; r < NREGS; r++) begin
      rf_d[r] = rf_q[r];
      if (wr_ok && (wr_addr == AW'(r))) begin
        rf_d[r] = wr_data;
      end
    end
  end

  // Storage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NREGS; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        rf_q[r] <= rf_d[r];
      end
    end
  end

  // Scoreboard next state: writeback clears, flush clears all, issue sets last.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (wr_ok && (wr_addr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
      if (flush) begin
        busy_d[r] = 1'b0;
      end
      if (iss_ok && (iss_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  // Scoreboard register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rf_flat[XLEN-1:0] = '0;
  assign busy_vec          = {busy_q, 1'b0};

  for (genvar r = 1; r < NREGS; r++) begin : g_flat
    assign rf_flat[r*XLEN +: XLEN] = rf_q[r];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rd (
      .rf_i      (rf_flat),
      .busy_i    (busy_vec),
      .wr_en_i   (byp_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rs_addr_i (rs_addr[i*AW +: AW]),
      .rs_data_o (rs_data[i*XLEN +: XLEN]),
      .rs_busy_o (rs_busy[i])
    );
  end

  assign stall = |(rs_used & rs_busy);

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a default 32x32/2-port instance and a
// 16x64/3-port instance, table vectors, corner sequences and random traffic.
module tb_reg_file_sb;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: XLEN=32, NREGS=32, NRD=2
  logic [9:0]  a_rs_addr;
  logic [1:0]  a_rs_used;
  logic [63:0] a_rs_data;
  logic [1:0]  a_rs_busy;
  logic        a_stall;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_iss_en;
  logic [4:0]  a_iss_rd;
  logic        a_flush;

  // Instance B: XLEN=64, NREGS=16, NRD=3
  logic [11:0]  b_rs_addr;
  logic [2:0]   b_rs_used;
  logic [191:0] b_rs_data;
  logic [2:0]   b_rs_busy;
  logic         b_stall;
  logic         b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_iss_en;
  logic [3:0]   b_iss_rd;
  logic         b_flush;

  reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .rs_addr(a_rs_addr), .rs_used(a_rs_used),
    .rs_data(a_rs_data), .rs_busy(a_rs_busy), .stall(a_stall),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_en(a_iss_en), .iss_rd(a_iss_rd), .flush(a_flush)
  );

  reg_file_sb #(.XLEN(64), .NREGS(16), .NRD(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs_addr(b_rs_addr), .rs_used(b_rs_used),
    .rs_data(b_rs_data), .rs_busy(b_rs_busy), .stall(b_stall),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_en(b_iss_en), .iss_rd(b_iss_rd), .flush(b_flush)
  );

  int nvec = 0;
  int nmis = 0;

  // Reference: register contents and pending-producer flags per instance.
  logic [63:0] m_rf   [2][32];
  bit          m_busy [2][32];

  typedef struct {
    bit          we;
    int          wa;
    logic [31:0] wd;
    bit          ie;
    int          ir;
    bit          fl;
    int          r0;
    int          r1;
    logic [1:0]  used;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  bz;
    bit          st;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(int d, int a, bit we, int wa, logic [63:0] wd);
    if (a == 0) return 64'h0;
    if (we && wa == a) return wd;
    return m_rf[d][a];
  endfunction

  function automatic bit exp_busy(int d, int a, bit we, int wa);
    if (a == 0) return 1'b0;
    if (we && wa == a) return 1'b0;
    return m_busy[d][a];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 32; r++) begin
        m_rf[d][r]   = 64'h0;
        m_busy[d][r] = 1'b0;
      end
  endtask

  task automatic model_edge(int d, bit we, int wa, logic [63:0] wd, bit ie, int ir, bit fl);
    if (we && wa != 0) begin
      m_rf[d][wa]   = wd;
      m_busy[d][wa] = 1'b0;
    end
    if (fl) for (int r = 0; r < 32; r++) m_busy[d][r] = 1'b0;
    if (ie && ir != 0) m_busy[d][ir] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0, a_wr_en, int'(a_wr_addr), 64'(a_wr_data), a_iss_en, int'(a_iss_rd), a_flush);
      model_edge(1, b_wr_en, int'(b_wr_addr), b_wr_data, b_iss_en, int'(b_iss_rd), b_flush);
    end
    #1;
  endtask

  task automatic drive_a(bit we, int wa, logic [31:0] wd, bit ie, int ir, bit fl,
                         int r0, int r1, logic [1:0] used);
    a_wr_en = we; a_wr_addr = 5'(wa); a_wr_data = wd;
    a_iss_en = ie; a_iss_rd = 5'(ir); a_flush = fl;
    a_rs_addr = {5'(r1), 5'(r0)}; a_rs_used = used;
    b_wr_en = 1'b0; b_iss_en = 1'b0; b_flush = 1'b0;
  endtask

  task automatic drive_b(bit we, int wa, logic [63:0] wd, bit ie, int ir, bit fl,
                         int r0, int r1, int r2, logic [2:0] used);
    b_wr_en = we; b_wr_addr = 4'(wa); b_wr_data = wd;
    b_iss_en = ie; b_iss_rd = 4'(ir); b_flush = fl;
    b_rs_addr = {4'(r2), 4'(r1), 4'(r0)}; b_rs_used = used;
    a_wr_en = 1'b0; a_iss_en = 1'b0; a_flush = 1'b0;
  endtask

  task automatic check_a(string tag);
    bit st = 1'b0;
    for (int p = 0; p < 2; p++) begin
      int ad = int'(a_rs_addr[p*5 +: 5]);
      bit eb = exp_busy(0, ad, a_wr_en, int'(a_wr_addr));
      chk($sformatf("%s_a_d%0d", tag, p), 64'(a_rs_data[p*32 +: 32]),
          exp_data(0, ad, a_wr_en, int'(a_wr_addr), 64'(a_wr_data)));
      chk($sformatf("%s_a_busy%0d", tag, p), 64'(a_rs_busy[p]), 64'(eb));
      st = st | (eb & a_rs_used[p]);
    end
    chk($sformatf("%s_a_stall", tag), 64'(a_stall), 64'(st));
  endtask

  task automatic check_b(string tag);
    bit st = 1'b0;
    for (int p = 0; p < 3; p++) begin
      int ad = int'(b_rs_addr[p*4 +: 4]);
      bit eb = exp_busy(1, ad, b_wr_en, int'(b_wr_addr));
      chk($sformatf("%s_b_d%0d", tag, p), b_rs_data[p*64 +: 64],
          exp_data(1, ad, b_wr_en, int'(b_wr_addr), b_wr_data));
      chk($sformatf("%s_b_busy%0d", tag, p), 64'(b_rs_busy[p]), 64'(eb));
      st = st | (eb & b_rs_used[p]);
    end
    chk($sformatf("%s_b_stall", tag), 64'(b_stall), 64'(st));
  endtask

  task automatic chk_b_all(string tag, logic [63:0] d0, logic [63:0] d1, logic [63:0] d2,
                           logic [2:0] bz, bit st);
    chk({tag, "_d0"}, b_rs_data[63:0], d0);
    chk({tag, "_d1"}, b_rs_data[127:64], d1);
    chk({tag, "_d2"}, b_rs_data[191:128], d2);
    chk({tag, "_busy"}, 64'(b_rs_busy), 64'(bz));
    chk({tag, "_stall"}, 64'(b_stall), 64'(st));
  endtask

  function automatic int pick(int n);
    if (($urandom % 4) == 0) return int'($urandom % n);
    return int'($urandom % 8);
  endfunction

  initial begin
    //          we    wa  wd            ie    ir fl    r0 r1 used   d0            d1            bz     st
    tbl[0]  = '{1'b0, 0, 32'h0,        1'b0, 0, 1'b0, 0, 1, 2'b11, 32'h0,        32'h0,        2'b00, 1'b0};
    tbl[1]  = '{1'b1, 3, 32'h12345678, 1'b0, 0, 1'b0, 3, 31, 2'b00, 32'h12345678, 32'h0,       2'b00, 1'b0};
    tbl[2]  = '{1'b0, 0, 32'h0,        1'b0, 0, 1'b0, 3, 3, 2'b11, 32'h12345678, 32'h12345678, 2'b00, 1'b0};
    tbl[3]  = '{1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 0, 0, 2'b11, 32'h0,        32'h0,        2'b00, 1'b0};
    tbl[4]  = '{1'b0, 0, 32'h0,        1'b0, 0, 1'b0, 0, 0, 2'b11, 32'h0,        32'h0,        2'b00, 1'b0};
    tbl[5]  = '{1'b0, 0, 32'h0,        1'b1, 7, 1'b0, 0, 7, 2'b10, 32'h0,        32'h0,        2'b00, 1'b0};
    tbl[6]  = '{1'b0, 0, 32'h0,        1'b0, 0, 1'b0, 0, 7, 2'b10, 32'h0,        32'h0,        2'b10, 1'b1};
    tbl[7]  = '{1'b0, 0, 32'h0,        1'b0, 0, 1'b0, 0, 7, 2'b00, 32'h0,        32'h0,        2'b10, 1'b0};
    tbl[8]  = '{1'b1, 7, 32'hA5,       1'b0, 0, 1'b0, 0, 7, 2'b10, 32'h0,        32'hA5,       2'b00, 1'b0};
    tbl[9]  = '{1'b0, 0, 32'h0,        1'b0, 0, 1'b0, 0, 7, 2'b10, 32'h0,        32'hA5,       2'b00, 1'b0};
    tbl[10] = '{1'b1, 9, 32'h1111,     1'b1, 9, 1'b0, 9, 0, 2'b01, 32'h1111,     32'h0,        2'b00, 1'b0};
    tbl[11] = '{1'b0, 0, 32'h0,        1'b0, 0, 1'b0, 9, 0, 2'b01, 32'h1111,     32'h0,        2'b01, 1'b1};
    tbl[12] = '{1'b0, 0, 32'h0,        1'b1, 4, 1'b0, 4, 6, 2'b11, 32'h0,        32'h0,        2'b00, 1'b0};
    tbl[13] = '{1'b0, 0, 32'h0,        1'b1, 6, 1'b0, 4, 6, 2'b11, 32'h0,        32'h0,        2'b01, 1'b1};
    tbl[14] = '{1'b0, 0, 32'h0,        1'b1, 8, 1'b1, 4, 6, 2'b11, 32'h0,        32'h0,        2'b11, 1'b1};
    tbl[15] = '{1'b0, 0, 32'h0,        1'b0, 0, 1'b0, 4, 8, 2'b11, 32'h0,        32'h0,        2'b10, 1'b1};
    tbl[16] = '{1'b0, 0, 32'h0,        1'b0, 0, 1'b0, 6, 9, 2'b11, 32'h0,        32'h1111,     2'b00, 1'b0};
    tbl[17] = '{1'b1, 8, 32'h88,       1'b0, 0, 1'b0, 8, 8, 2'b11, 32'h88,       32'h88,       2'b00, 1'b0};
    tbl[18] = '{1'b0, 0, 32'h0,        1'b0, 0, 1'b0, 8, 3, 2'b11, 32'h88,       32'h12345678, 2'b00, 1'b0};

    rst_n = 1'b0;
    drive_a(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 0, 0, 2'b00);
    drive_b(1'b0, 0, 64'h0, 1'b0, 0, 1'b0, 0, 0, 0, 3'b000);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Post-reset sweep of every address on both ports.
    for (int a = 0; a < 32; a++) begin
      drive_a(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, a, 31 - a, 2'b11);
      #1;
      chk($sformatf("rst_sweep_d0_x%0d", a), 64'(a_rs_data[31:0]), 64'h0);
      chk($sformatf("rst_sweep_d1_x%0d", 31 - a), 64'(a_rs_data[63:32]), 64'h0);
      chk($sformatf("rst_sweep_stall_%0d", a), 64'(a_stall), 64'h0);
    end
    tick();

    // Directed table on instance A.
    for (int i = 0; i < 19; i++) begin
      drive_a(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ie, tbl[i].ir, tbl[i].fl,
              tbl[i].r0, tbl[i].r1, tbl[i].used);
      #3;
      check_a($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_d0", i), 64'(a_rs_data[31:0]), 64'(tbl[i].d0));
      chk($sformatf("tbl%0d_d1", i), 64'(a_rs_data[63:32]), 64'(tbl[i].d1));
      chk($sformatf("tbl%0d_busy", i), 64'(a_rs_busy), 64'(tbl[i].bz));
      chk($sformatf("tbl%0d_stall", i), 64'(a_stall), 64'(tbl[i].st));
      tick();
    end

    // Asynchronous reset between clock edges, and writes ignored during reset.
    drive_a(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 5, 3, 2'b00);
    #3;
    check_a("wr_x5");
    tick();
    drive_a(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 5, 3, 2'b11);
    #2;
    chk("x5_before_rst", 64'(a_rs_data[31:0]), 64'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("x5_async_rst", 64'(a_rs_data[31:0]), 64'h0);
    chk("x3_async_rst", 64'(a_rs_data[63:32]), 64'h0);
    model_reset();
    drive_a(1'b1, 5, 32'hCAFEF00D, 1'b1, 5, 1'b0, 5, 5, 2'b11);
    #1;
    chk("bypass_in_rst", 64'(a_rs_data[31:0]), 64'h0);
    chk("busy_in_rst", 64'(a_rs_busy), 64'h0);
    chk("stall_in_rst", 64'(a_stall), 64'h0);
    tick();
    drive_a(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 5, 5, 2'b11);
    rst_n = 1'b1;
    #3;
    chk("x5_after_rst", 64'(a_rs_data[31:0]), 64'h0);
    chk("x5_busy_after_rst", 64'(a_rs_busy), 64'h0);
    check_a("post_rst");
    tick();

    // Random traffic on instance A.
    for (int i = 0; i < 400; i++) begin
      drive_a(($urandom % 2) == 1, pick(32), $urandom, ($urandom % 2) == 1, pick(32),
              ($urandom % 16) == 0, pick(32), pick(32), 2'($urandom % 4));
      #3;
      check_a("rndA");
      tick();
    end

    // Instance B: 64-bit data, three aliasing ports.
    drive_b(1'b1, 3, 64'h0123456789ABCDEF, 1'b0, 0, 1'b0, 3, 3, 3, 3'b111);
    #3; check_b("b1");
    chk_b_all("b1", 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 3'b000, 1'b0);
    tick();
    drive_b(1'b0, 0, 64'h0, 1'b0, 0, 1'b0, 3, 3, 3, 3'b111);
    #3; check_b("b2");
    chk_b_all("b2", 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 3'b000, 1'b0);
    tick();
    drive_b(1'b0, 0, 64'h0, 1'b1, 7, 1'b0, 7, 7, 7, 3'b111);
    #3; check_b("b3");
    chk_b_all("b3", 64'h0, 64'h0, 64'h0, 3'b000, 1'b0);
    tick();
    drive_b(1'b0, 0, 64'h0, 1'b0, 0, 1'b0, 7, 7, 7, 3'b111);
    #3; check_b("b4");
    chk_b_all("b4", 64'h0, 64'h0, 64'h0, 3'b111, 1'b1);
    tick();
    drive_b(1'b1, 7, 64'hFEDCBA9876543210, 1'b1, 7, 1'b0, 7, 7, 7, 3'b111);
    #3; check_b("b5");
    chk_b_all("b5", 64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 3'b000, 1'b0);
    tick();
    drive_b(1'b0, 0, 64'h0, 1'b0, 0, 1'b0, 7, 7, 7, 3'b001);
    #3; check_b("b6");
    chk_b_all("b6", 64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 3'b111, 1'b1);
    tick();
    drive_b(1'b0, 0, 64'h0, 1'b1, 4, 1'b0, 4, 8, 15, 3'b111);
    #3; check_b("b7");
    tick();
    drive_b(1'b0, 0, 64'h0, 1'b1, 8, 1'b1, 4, 8, 7, 3'b111);
    #3; check_b("b8");
    chk_b_all("b8", 64'h0, 64'h0, 64'hFEDCBA9876543210, 3'b101, 1'b1);
    tick();
    drive_b(1'b0, 0, 64'h0, 1'b0, 0, 1'b0, 4, 8, 7, 3'b111);
    #3; check_b("b9");
    chk_b_all("b9", 64'h0, 64'h0, 64'hFEDCBA9876543210, 3'b010, 1'b1);
    tick();
    drive_b(1'b1, 0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 0, 1'b0, 0, 0, 15, 3'b111);
    #3; check_b("b10");
    chk_b_all("b10", 64'h0, 64'h0, 64'h0, 3'b000, 1'b0);
    tick();
    drive_b(1'b0, 0, 64'h0, 1'b0, 0, 1'b0, 0, 0, 3, 3'b111);
    #3; check_b("b11");
    chk_b_all("b11", 64'h0, 64'h0, 64'h0123456789ABCDEF, 3'b000, 1'b0);
    tick();

    // Random traffic on instance B.
    for (int i = 0; i < 300; i++) begin
      drive_b(($urandom % 2) == 1, pick(16), {$urandom, $urandom}, ($urandom % 2) == 1, pick(16),
              ($urandom % 16) == 0, pick(16), pick(16), pick(16), 3'($urandom % 8));
      #3;
      check_b("rndB");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file with per-register scoreboard, the successor to the monocycle CPU register unit, targeting the pipelined core. It provides NRD combinational read ports with write-to-read bypass and one synchronous write port. Register 0 is hardwired to zero. A busy bit per register tracks in-flight destination writes and produces a stall request for the decode stage.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports
AW, $clog2(NREGS), register address width (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW]
rs_used  in  NRD  port i operand actually needed by the decoded instruction
rs_data  out  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
rs_busy  out  NRD  port i register has a pending write not yet available
stall  out  1  decode must hold: OR over i of (rs_used[i] & rs_busy[i])
wr_en  in  1  writeback enable
wr_addr  in  AW  writeback destination
wr_data  in  XLEN  writeback data
iss_en  in  1  instruction issued this cycle with a destination
iss_rd  in  AW  issued destination register
flush  in  1  pipeline flush: clear all busy bits

Behaviour:
- Reset (rst_n low, asynchronous): all NREGS data registers = 0 and all busy bits = 0, regardless of clk. While in reset: rs_data = 0, rs_busy = 0, stall = 0. A write or issue in the same cycle that reset deasserts is ignored if rst_n is sampled low at that edge.
- Write: at posedge, if wr_en && wr_addr != 0, then RF[wr_addr] <= wr_data. Writes to x0 are dropped.
- Read (combinational, zero latency):
  - rs_addr == 0 -> 0.
  - else if wr_en && wr_addr == rs_addr -> wr_data (bypass, write-first).
  - else -> RF[rs_addr].
- Busy update at posedge, evaluated in this order (later steps win):
  1. wr_en && wr_addr != 0 -> clear busy[wr_addr].
  2. flush -> clear all busy bits.
  3. iss_en && iss_rd != 0 -> set busy[iss_rd].
- Simultaneous events:
  - Write and issue to the same register: busy ends up 1, because the new producer wins.
  - Flush and issue in the same cycle: only iss_rd is busy afterwards.
- rs_busy[i] = busy[rs_addr_i] & ~(wr_en && wr_addr == rs_addr_i). The bypass makes the value available in the writeback cycle. rs_busy is always 0 for x0.
- stall is purely combinational from the current inputs and state. It has no registered latency.
- Out-of-range addresses cannot occur, because NREGS is a power of two.
- busy[0] is held at constant 0. No storage flop exists for x0.
- Any number of read ports may alias the same address. Each port resolves independently.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN_DEF = 32 and NREGS_DEF = 32.
  - typedef reg_addr_t (logic [AW-1:0]).
  - typedef xword_t (logic [XLEN-1:0]).
  - constant REG_ZERO = '0.
- One sub-module, rf_read_port, is natural. It takes the array, busy vector, write-port signals and one address, and returns data and busy. It is instantiated NRD times in a generate loop.
- The storage array, busy vector and stall OR-reduction stay in the top-level module.

Test Plan:
- Reset, then read all addresses on both ports -> every rs_data = 0 and stall = 0. Assert rst_n low mid-run after writing x5 = 0xDEADBEEF, without any clk edge -> reading x5 returns 0 immediately.
- Write x3 = 0x12345678 with rs_addr0 = 3 in the same cycle -> rs_data0 = 0x12345678 combinationally. The next cycle, with wr_en = 0, still reads 0x12345678. Write x0 = 0xFFFFFFFF -> x0 reads 0 on both ports.
- Issue iss_rd = 7, then the next cycle rs_addr1 = 7 with rs_used1 = 1 -> rs_busy1 = 1 and stall = 1. With rs_used1 = 0 -> stall = 0. Then wr_en to x7 = 0xA5 -> in that cycle rs_busy1 = 0, stall = 0, rs_data1 = 0xA5.
- Same cycle wr_en to x9 and iss_en to x9 -> afterwards busy[9] = 1 and stall is asserted on a read of x9.
- Issue x4 and x6, then flush together with iss_rd = 8 -> x4 and x6 are not busy, x8 is busy.
- Parameter sweep NREGS = 16, XLEN = 64, NRD = 3 -> repeat the scenarios with 64-bit patterns (0x0123456789ABCDEF), and check that all three ports resolve aliasing of the same address identically.
